// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep controller: sweep modes, FSM states and default widths.
package dds_pkg;

  localparam int unsigned DDS_PHASE_W = 32;
  localparam int unsigned DDS_DWELL_W = 16;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRunUp   = 2'd1,
    StRunDown = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep controller feeding the DDS core's tuning word and clock enable.
// Supports single up-ramp, repeating sawtooth and triangle chirps with a per-word dwell time.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned PHASE_W = DDS_PHASE_W,
  parameter int unsigned DWELL_W = DDS_DWELL_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [1:0]         mode_i,
  input  logic [PHASE_W-1:0] start_word_i,
  input  logic [PHASE_W-1:0] stop_word_i,
  input  logic [PHASE_W-1:0] step_word_i,
  input  logic [DWELL_W-1:0] dwell_cycles_i,
  output logic [PHASE_W-1:0] freq_word_o,
  output logic               clk_en_o,
  output logic               busy_o,
  output logic               step_strobe_o,
  output logic               done_o,
  output logic               err_o
);

  sweep_state_e       state_q;
  logic [1:0]         mode_q;
  logic [PHASE_W-1:0] start_word_q;
  logic [PHASE_W-1:0] stop_word_q;
  logic [PHASE_W-1:0] step_word_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_cnt_q;
  logic [PHASE_W-1:0] freq_word_q;
  logic               clk_en_q;
  logic               busy_q;
  logic               step_strobe_q;
  logic               done_q;
  logic               err_q;

  logic               cfg_illegal;
  logic [PHASE_W:0]   up_sum;
  logic               up_over;
  logic [PHASE_W:0]   dn_diff;
  logic               dn_under;

  assign cfg_illegal = (step_word_i == '0) || (start_word_i > stop_word_i) ||
                       (mode_i == MODE_RSVD);

  // One extra bit so an overflowing up-step compares as beyond the stop word.
  assign up_sum  = {1'b0, freq_word_q} + {1'b0, step_word_q};
  assign up_over = up_sum > {1'b0, stop_word_q};

  // The MSB is the borrow; only a start-word freq can underflow below start (single-word ramp).
  assign dn_diff  = {1'b0, freq_word_q} - {1'b0, step_word_q};
  assign dn_under = dn_diff[PHASE_W] || (dn_diff[PHASE_W-1:0] < start_word_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      mode_q        <= MODE_SINGLE;
      start_word_q  <= '0;
      stop_word_q   <= '0;
      step_word_q   <= '0;
      dwell_q       <= '0;
      dwell_cnt_q   <= '0;
      freq_word_q   <= '0;
      clk_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      step_strobe_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      step_strobe_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;

      case (state_q)
        StIdle: begin
          if (start_i && !abort_i) begin
            if (cfg_illegal) begin
              err_q <= 1'b1;
            end else begin
              mode_q       <= mode_i;
              start_word_q <= start_word_i;
              stop_word_q  <= stop_word_i;
              step_word_q  <= step_word_i;
              dwell_q      <= dwell_cycles_i;
              dwell_cnt_q  <= dwell_cycles_i;
              freq_word_q  <= start_word_i;
              clk_en_q     <= 1'b1;
              busy_q       <= 1'b1;
              state_q      <= StRunUp;
            end
          end
        end

        StRunUp, StRunDown: begin
          if (abort_i) begin
            clk_en_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end else if (dwell_cnt_q != '0) begin
            dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
          end else begin
            dwell_cnt_q <= dwell_q;
            if (state_q == StRunUp) begin
              if (!up_over) begin
                freq_word_q   <= up_sum[PHASE_W-1:0];
                step_strobe_q <= 1'b1;
              end else begin
                case (mode_q)
                  MODE_SAW: begin
                    freq_word_q   <= start_word_q;
                    step_strobe_q <= 1'b1;
                  end
                  MODE_TRI: begin
                    step_strobe_q <= 1'b1;
                    if (dn_under) begin
                      // Single-word ramp: hold the start word like a sawtooth.
                      freq_word_q <= start_word_q;
                    end else begin
                      freq_word_q <= dn_diff[PHASE_W-1:0];
                      state_q     <= StRunDown;
                    end
                  end
                  default: begin
                    clk_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= StIdle;
                  end
                endcase
              end
            end else begin
              step_strobe_q <= 1'b1;
              if (dn_under) begin
                freq_word_q <= up_sum[PHASE_W-1:0];
                state_q     <= StRunUp;
              end else begin
                freq_word_q <= dn_diff[PHASE_W-1:0];
              end
            end
          end
        end

        default: begin
          clk_en_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign freq_word_o   = freq_word_q;
  assign clk_en_o      = clk_en_q;
  assign busy_o        = busy_q;
  assign step_strobe_o = step_strobe_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed chirps, rejects, abort/reset and random sweeps
// compared against a closed-form model of the expected word sequence.
module tb_dds_sweep_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        abort_i;
  logic [1:0]  mode_i;
  logic [31:0] start_word_i;
  logic [31:0] stop_word_i;
  logic [31:0] step_word_i;
  logic [15:0] dwell_cycles_i;
  logic [31:0] freq_word_o;
  logic        clk_en_o;
  logic        busy_o;
  logic        step_strobe_o;
  logic        done_o;
  logic        err_o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_freq;

  dds_sweep_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .mode_i         (mode_i),
    .start_word_i   (start_word_i),
    .stop_word_i    (stop_word_i),
    .step_word_i    (step_word_i),
    .dwell_cycles_i (dwell_cycles_i),
    .freq_word_o    (freq_word_o),
    .clk_en_o       (clk_en_o),
    .busy_o         (busy_o),
    .step_strobe_o  (step_strobe_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".freq"}, 64'(freq_word_o), 64'(exp_freq));
    check({tag, ".clk_en"}, 64'(clk_en_o), 64'd0);
    check({tag, ".busy"}, 64'(busy_o), 64'd0);
    check({tag, ".strobe"}, 64'(step_strobe_o), 64'd0);
    check({tag, ".done"}, 64'(done_o), 64'd0);
    check({tag, ".err"}, 64'(err_o), 64'd0);
  endtask

  // Ramp words are sw + i*st for i in [0, L). The output dwells d clocks on each word;
  // index k of the dwell slot picks the word according to the chirp shape.
  function automatic void model(input logic [1:0] m, input longint unsigned sw,
                                input longint unsigned pw, input longint unsigned st,
                                input int dw, input int t, output logic [31:0] w,
                                output bit strobe, output bit done, output bit active);
    longint unsigned len, d, k, idx, per, j;
    len = (pw - sw) / st + 1;
    d = longint'(dw) + 1;
    k = longint'(t) / d;
    done = 0;
    strobe = 0;
    active = 1;
    idx = 0;
    if (m == 2'd0 && k >= len) begin
      active = 0;
      done = (longint'(t) == len * d);
      idx = len - 1;
    end else begin
      strobe = (t > 0) && (longint'(t) % d == 0);
      if (m == 2'd0) idx = k;
      else if (m == 2'd1) idx = k % len;
      else begin
        per = (len == 1) ? 1 : 2 * len - 2;
        j = k % per;
        idx = (j < len) ? j : per - j;
      end
    end
    w = 32'(sw + idx * st);
  endfunction

  task automatic run_sweep(input logic [1:0] m, input logic [31:0] sw, input logic [31:0] pw,
                           input logic [31:0] st, input logic [15:0] dw, input int ncyc,
                           input int poke_at, input bit end_reset);
    logic [31:0] w;
    bit          strobe, done, active;
    mode_i = m;
    start_word_i = sw;
    stop_word_i = pw;
    step_word_i = st;
    dwell_cycles_i = dw;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      model(m, longint'(sw), longint'(pw), longint'(st), int'(dw), t, w, strobe, done, active);
      if (!active) begin
        exp_freq = w;
        check("single.freq_hold", 64'(freq_word_o), 64'(w));
        check("single.clk_en", 64'(clk_en_o), 64'd0);
        check("single.busy", 64'(busy_o), 64'd0);
        check("single.done", 64'(done_o), 64'(done));
        check("single.strobe", 64'(step_strobe_o), 64'd0);
        tick();
        check_idle("after_done");
        return;
      end
      check("run.freq", 64'(freq_word_o), 64'(w));
      check("run.clk_en", 64'(clk_en_o), 64'd1);
      check("run.busy", 64'(busy_o), 64'd1);
      check("run.strobe", 64'(step_strobe_o), 64'(strobe));
      check("run.done", 64'(done_o), 64'd0);
      check("run.err", 64'(err_o), 64'd0);
      if (m != 2'd0 && t == ncyc - 1) begin
        exp_freq = w;
        if (end_reset) begin
          rst_i = 1'b1;
          #1;
          exp_freq = '0;
          check_idle("reset_async");
          tick();
          rst_i = 1'b0;
          tick();
          check_idle("reset_release");
        end else begin
          abort_i = 1'b1;
          tick();
          abort_i = 1'b0;
          check_idle("abort");
          tick();
          check_idle("abort_stay");
        end
        return;
      end
      if (t == poke_at) begin
        start_i = 1'b1;
        mode_i = 2'($urandom);
        start_word_i = $urandom_range(0, 100);
        stop_word_i = $urandom_range(200, 100000);
        step_word_i = $urandom_range(1, 50);
        dwell_cycles_i = 16'($urandom_range(0, 5));
      end else begin
        start_i = 1'b0;
      end
      tick();
    end
    check("sweep_bound", 64'd1, 64'd0);
  endtask

  task automatic reject(input string tag, input logic [1:0] m, input logic [31:0] sw,
                        input logic [31:0] pw, input logic [31:0] st);
    mode_i = m;
    start_word_i = sw;
    stop_word_i = pw;
    step_word_i = st;
    dwell_cycles_i = 16'd1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check({tag, ".err"}, 64'(err_o), 64'd1);
    check({tag, ".busy"}, 64'(busy_o), 64'd0);
    check({tag, ".clk_en"}, 64'(clk_en_o), 64'd0);
    check({tag, ".freq"}, 64'(freq_word_o), 64'(exp_freq));
    check({tag, ".strobe"}, 64'(step_strobe_o), 64'd0);
    tick();
    check_idle({tag, ".after"});
  endtask

  initial begin
    logic [1:0]  m;
    logic [31:0] sw, pw, st;
    logic [15:0] dw;
    int          n;
    rst_i = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    mode_i = '0;
    start_word_i = '0;
    stop_word_i = '0;
    step_word_i = '0;
    dwell_cycles_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    exp_freq = '0;
    check_idle("reset");
    rst_i = 1'b0;
    tick();
    check_idle("post_reset");

    run_sweep(2'd0, 32'd100, 32'd130, 32'd10, 16'd1, 0, -1, 1'b0);
    run_sweep(2'd1, 32'd0, 32'd20, 32'd10, 16'd0, 10, 4, 1'b0);
    run_sweep(2'd2, 32'd10, 32'd40, 32'd10, 16'd0, 14, 3, 1'b0);
    run_sweep(2'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 16'd2, 0, -1, 1'b0);

    reject("rej_step0", 2'd0, 32'd10, 32'd40, 32'd0);
    reject("rej_order", 2'd1, 32'd50, 32'd40, 32'd5);
    reject("rej_mode3", 2'd3, 32'd10, 32'd40, 32'd5);

    mode_i = 2'd1;
    start_word_i = 32'd5;
    stop_word_i = 32'd50;
    step_word_i = 32'd5;
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    check_idle("start_abort");
    tick();
    check_idle("start_abort_stay");

    run_sweep(2'd2, 32'd10, 32'd40, 32'd10, 16'd0, 9, -1, 1'b1);
    run_sweep(2'd2, 32'd50, 32'd54, 32'd7, 16'd1, 8, -1, 1'b0);
    run_sweep(2'd1, 32'd50, 32'd54, 32'd7, 16'd2, 8, -1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      m = 2'($urandom_range(0, 2));
      st = $urandom_range(1, 1000);
      sw = $urandom_range(0, 1 << 20);
      n = $urandom_range(0, 5);
      pw = sw + 32'(n) * st + $urandom_range(0, st - 1);
      dw = 16'($urandom_range(0, 3));
      run_sweep(m, sw, pw, st, dw, $urandom_range(5, 40), $urandom_range(0, 10), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
